// File: rtl/aqua_pkg.sv
// Shared constants and the fetch-queue entry type for the aqua front end.
package aqua_pkg;

    localparam int XLEN     = 32;
    localparam int ILEN     = 32;
    localparam int FQ_DEPTH = 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/aqua_fetch_queue.sv
// 2-wide in-order instruction queue between fetch and the dual-issue decoder.
// First-word-fall-through read view; a redirect flush discards all contents.
module aqua_fetch_queue
    import aqua_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int XLEN  = aqua_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            f_pc_i,
    input  logic [2*XLEN-1:0]          f_instr_i,
    input  logic [1:0]                 f_vld_i,
    output logic                       f_stall_o,
    output logic [2*XLEN-1:0]          d_instr_o,
    output logic [XLEN-1:0]            d_pc0_o,
    output logic [XLEN-1:0]            d_pc1_o,
    output logic [1:0]                 d_vld_o,
    input  logic [1:0]                 d_take_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fq_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    logic [PW-1:0]     rd_ptr1;
    logic [PW-1:0]     wr_ptr1;
    logic              enq_ok;
    fq_entry_t         slot0_e;
    fq_entry_t         slot1_e;
    fq_entry_t         wr_data0;
    fq_entry_t         wr_data1;
    logic              wr_en0;
    logic              wr_en1;
    logic [1:0]        n_enq;
    logic [1:0]        take_eff;
    logic [1:0]        n_deq;
    logic [CW-1:0]     count_next;

    assign rd_ptr1 = rd_ptr + PW'(1);
    assign wr_ptr1 = wr_ptr + PW'(1);

    // Stall from registered occupancy only: fewer than two free slots.
    assign f_stall_o = (count > CW'(DEPTH - 2));
    assign enq_ok    = !f_stall_o && !flush_i;

    assign slot0_e = '{pc: f_pc_i,             instr: f_instr_i[ILEN-1:0]};
    assign slot1_e = '{pc: f_pc_i + XLEN'(4),  instr: f_instr_i[2*ILEN-1:ILEN]};

    // Compact valid slots so the oldest always lands at wr_ptr.
    always_comb begin
        wr_en0   = 1'b0;
        wr_en1   = 1'b0;
        wr_data0 = slot0_e;
        wr_data1 = slot1_e;
        n_enq    = 2'd0;
        if (enq_ok) begin
            unique case (f_vld_i)
                2'b01: begin
                    wr_en0 = 1'b1;
                    n_enq  = 2'd1;
                end
                2'b10: begin
                    wr_en0   = 1'b1;
                    wr_data0 = slot1_e;
                    n_enq    = 2'd1;
                end
                2'b11: begin
                    wr_en0 = 1'b1;
                    wr_en1 = 1'b1;
                    n_enq  = 2'd2;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (count == '0)
            d_vld_o = 2'b00;
        else if (count == CW'(1))
            d_vld_o = 2'b01;
        else
            d_vld_o = 2'b11;
    end

    // The illegal 10 pattern is treated as no take.
    always_comb begin
        unique case (d_take_i)
            2'b01:   take_eff = d_vld_o & 2'b01;
            2'b11:   take_eff = d_vld_o;
            default: take_eff = 2'b00;
        endcase
        n_deq = {1'b0, take_eff[0]} + {1'b0, take_eff[1]};
    end

    assign count_next = count + CW'(n_enq) - CW'(n_deq);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PW'(n_deq);
            wr_ptr <= wr_ptr + PW'(n_enq);
            count  <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en0)
            mem[wr_ptr] <= wr_data0;
        if (wr_en1)
            mem[wr_ptr1] <= wr_data1;
    end

    always_comb begin
        d_instr_o = '0;
        d_pc0_o   = '0;
        d_pc1_o   = '0;
        if (d_vld_o[0]) begin
            d_instr_o[ILEN-1:0] = mem[rd_ptr].instr;
            d_pc0_o             = mem[rd_ptr].pc;
        end
        if (d_vld_o[1]) begin
            d_instr_o[2*ILEN-1:ILEN] = mem[rd_ptr1].instr;
            d_pc1_o                  = mem[rd_ptr1].pc;
        end
    end

    assign count_o = count;

    take_pattern_legal: assert property (@(posedge clk) disable iff (rst)
        d_take_i != 2'b10)
        else $error("aqua_fetch_queue: illegal d_take_i=10");

    occupancy_bounded: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH))
        else $error("aqua_fetch_queue: occupancy above DEPTH");

endmodule

// File: tb/tb_aqua_fetch_queue.sv
// Directed bench for aqua_fetch_queue: hand-computed expectations at each step.
module tb_aqua_fetch_queue;

    localparam int DEPTH = 8;
    localparam int XLEN  = 32;
    localparam logic [31:0] K = 32'h1357_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [XLEN-1:0]   f_pc;
    logic [2*XLEN-1:0] f_instr;
    logic [1:0]        f_vld;
    logic              f_stall;
    logic [2*XLEN-1:0] d_instr;
    logic [XLEN-1:0]   d_pc0;
    logic [XLEN-1:0]   d_pc1;
    logic [1:0]        d_vld;
    logic [1:0]        d_take;
    logic [3:0]        count;

    int checks = 0;
    int errors = 0;

    aqua_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush),
        .f_pc_i    (f_pc),
        .f_instr_i (f_instr),
        .f_vld_i   (f_vld),
        .f_stall_o (f_stall),
        .d_instr_o (d_instr),
        .d_pc0_o   (d_pc0),
        .d_pc1_o   (d_pc1),
        .d_vld_o   (d_vld),
        .d_take_i  (d_take),
        .count_o   (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pair(input logic [31:0] pc);
        return {(pc + 32'd4) ^ K, pc ^ K};
    endfunction

    initial begin
        logic [31:0] exp_pc;

        rst = 1'b1; flush = 1'b0; f_pc = '0; f_instr = '0; f_vld = 2'b00; d_take = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_stall", f_stall, 0);
        chk("rst_vld", d_vld, 0);
        chk("rst_instr", d_instr, 0);
        chk("rst_pc0", d_pc0, 0);
        chk("rst_pc1", d_pc1, 0);

        // Pair A/B at PC 0
        f_pc = 32'h0; f_instr = 64'hBBBB0002_AAAA0001; f_vld = 2'b11;
        tick();
        f_vld = 2'b00;
        chk("ab_vld", d_vld, 2'b11);
        chk("ab_pc0", d_pc0, 32'h0);
        chk("ab_pc1", d_pc1, 32'h4);
        chk("ab_count", count, 2);
        chk("ab_instr", d_instr, 64'hBBBB0002_AAAA0001);
        d_take = 2'b11;
        tick();
        d_take = 2'b00;
        chk("ab_drain_count", count, 0);
        chk("ab_drain_vld", d_vld, 2'b00);

        // Mid-pair entry: only slot 1 valid
        f_pc = 32'h10; f_instr = 64'hCCCC0003_DEADBEEF; f_vld = 2'b10;
        tick();
        f_vld = 2'b00;
        chk("mid_vld", d_vld, 2'b01);
        chk("mid_pc0", d_pc0, 32'h14);
        chk("mid_instr", d_instr, 64'h00000000_CCCC0003);
        chk("mid_pc1", d_pc1, 32'h0);
        chk("mid_count", count, 1);

        // Take 11 with one valid entry consumes just one
        d_take = 2'b11;
        tick();
        d_take = 2'b00;
        chk("mask_count", count, 0);
        chk("mask_vld", d_vld, 2'b00);

        // Fill to full with four pairs
        for (int i = 0; i < 4; i++) begin
            f_pc = 32'h100 + 32'(8 * i); f_instr = pair(f_pc); f_vld = 2'b11;
            tick();
            chk("fill_count", count, 64'(2 * (i + 1)));
            chk("fill_stall", f_stall, (i == 3) ? 64'd1 : 64'd0);
        end
        f_pc = 32'h200; f_instr = pair(f_pc); f_vld = 2'b11;
        tick();
        chk("full_hold_count", count, 8);
        d_take = 2'b01;
        tick();
        chk("c7_count", count, 7);
        chk("c7_stall", f_stall, 1);
        chk("c7_pc0", d_pc0, 32'h104);
        d_take = 2'b00;
        tick();
        chk("c7_nowrite_count", count, 7);
        chk("c7_nowrite_pc0", d_pc0, 32'h104);
        d_take = 2'b11;
        tick();
        d_take = 2'b00; f_vld = 2'b00;
        chk("c5_count", count, 5);
        chk("c5_stall", f_stall, 0);
        chk("c5_pc0", d_pc0, 32'h10C);
        chk("c5_pc1", d_pc1, 32'h110);
        chk("c5_instr", d_instr, pair(32'h10C));

        // Flush wins over simultaneous enqueue and take
        flush = 1'b1; f_pc = 32'h300; f_instr = pair(f_pc); f_vld = 2'b11; d_take = 2'b11;
        tick();
        flush = 1'b0; f_vld = 2'b00; d_take = 2'b00;
        chk("flush_count", count, 0);
        chk("flush_vld", d_vld, 2'b00);
        chk("flush_stall", f_stall, 0);
        chk("flush_pc0", d_pc0, 32'h0);
        chk("flush_instr", d_instr, 64'h0);

        f_pc = 32'h34; f_instr = pair(f_pc); f_vld = 2'b11;
        tick();
        chk("post_flush_pc0", d_pc0, 32'h34);
        chk("post_flush_pc1", d_pc1, 32'h38);
        chk("post_flush_vld", d_vld, 2'b11);
        chk("post_flush_count", count, 2);

        // Steady state: enqueue 2 and dequeue 2 every cycle across pointer wrap
        exp_pc = 32'h3C;
        for (int i = 0; i < 20; i++) begin
            f_pc = exp_pc; f_instr = pair(exp_pc); f_vld = 2'b11; d_take = 2'b11;
            tick();
            chk("ss_count", count, 2);
            chk("ss_pc0", d_pc0, exp_pc);
            chk("ss_pc1", d_pc1, exp_pc + 32'd4);
            chk("ss_instr", d_instr, pair(exp_pc));
            exp_pc = exp_pc + 32'd8;
        end
        f_vld = 2'b00; d_take = 2'b11;
        tick();
        d_take = 2'b00;
        chk("ss_drain_count", count, 0);

        // PC +4 wraps modulo 2^XLEN
        f_pc = 32'hFFFF_FFFC; f_instr = 64'h22222222_11111111; f_vld = 2'b11;
        tick();
        f_vld = 2'b00;
        chk("wrap_pc0", d_pc0, 32'hFFFF_FFFC);
        chk("wrap_pc1", d_pc1, 32'h0);
        d_take = 2'b01;
        tick();
        d_take = 2'b00;
        chk("take01_count", count, 1);
        chk("take01_pc0", d_pc0, 32'h0);
        chk("take01_instr", d_instr, 64'h00000000_22222222);
        chk("take01_vld", d_vld, 2'b01);

        // Reset in the middle of filling
        f_pc = 32'h500; f_instr = pair(f_pc); f_vld = 2'b11;
        tick();
        chk("prerst_count", count, 3);
        f_pc = 32'h508; f_instr = pair(f_pc); rst = 1'b1;
        tick();
        rst = 1'b0; f_vld = 2'b00;
        chk("mrst_count", count, 0);
        chk("mrst_vld", d_vld, 2'b00);
        chk("mrst_stall", f_stall, 0);
        chk("mrst_pc0", d_pc0, 32'h0);
        chk("mrst_pc1", d_pc1, 32'h0);
        chk("mrst_instr", d_instr, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
